// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter state encoding, baud divisors for a 50 MHz
// clock and default handshake timeouts.
package uart_pkg;

  typedef enum logic [1:0] {
    ARB       = 2'd0,
    ISSUE     = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_e;

  localparam logic [15:0] BPS_NUM_115200 = 16'd434;
  localparam logic [15:0] BPS_NUM_9600   = 16'd5208;
  localparam logic [15:0] BPS_NUM_4800   = 16'd10417;

  localparam logic [15:0] ACK_TIMEOUT_DEF  = 16'd8;
  localparam logic [31:0] LOCK_TIMEOUT_DEF = 32'd50000000;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams plus the uart_tx pulse/busy handshake.
// slave is the arbiter's view; master is the requesters and transmitter side.
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           tx_data;
  logic                 tx_pluse;
  logic                 tx_busy;

  modport master (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, tx_data, tx_pluse
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, tx_data, tx_pluse
  );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: first set bit of req_i scanning upward
// from ptr_i with wrap-around.
module rr_pick #(
  parameter int unsigned N = 4,
  parameter int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic         found_o,
  output logic [W-1:0] idx_o
);

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      int unsigned c;
      c = (32'(ptr_i) + i) % N;
      if (!found_o && req_i[c[W-1:0]]) begin
        found_o = 1'b1;
        idx_o   = c[W-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locking arbiter sharing one uart_tx among NUM_REQ byte
// sources; owns the pulse/busy handshake with ack and lock-idle timeouts.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter logic [15:0] ACK_TIMEOUT  = ACK_TIMEOUT_DEF,
  parameter logic [31:0] LOCK_TIMEOUT = LOCK_TIMEOUT_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  uart_tx_arbiter_if.slave           bus,
  output logic [$clog2(NUM_REQ)-1:0] gnt_id,
  output logic                       gnt_lock,
  output logic                       ack_err,
  output logic                       lock_err,
  output logic [15:0]                tx_cnt
);

  localparam int unsigned IDW = $clog2(NUM_REQ);

  arb_state_e       state_q;
  logic [IDW-1:0]   rr_ptr_q;
  logic [IDW-1:0]   gnt_id_q;
  logic             gnt_lock_q;
  logic [7:0]       tx_data_q;
  logic             tx_pluse_q;
  logic             last_q;
  logic [15:0]      ack_cnt_q;
  logic [31:0]      idle_cnt_q;
  logic             ack_err_q;
  logic             lock_err_q;
  logic [15:0]      tx_cnt_q;

  logic [NUM_REQ-1:0] elig;
  logic [IDW-1:0]     pick_ptr;
  logic [IDW-1:0]     pick_idx;
  logic               pick_found;
  logic               win;
  logic [7:0]         byte_d;
  logic               last_d;

  function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
    if (32'(id) == NUM_REQ - 1) return '0;
    return id + 1'b1;
  endfunction

  // While locked only the owner of the packet is eligible.
  always_comb begin
    elig     = gnt_lock_q ? (bus.req_valid & (NUM_REQ'(1) << gnt_id_q)) : bus.req_valid;
    pick_ptr = gnt_lock_q ? gnt_id_q : rr_ptr_q;
  end

  rr_pick #(.N(NUM_REQ), .W(IDW)) u_rr_pick (
    .req_i   (elig),
    .ptr_i   (pick_ptr),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_comb begin
    win    = (state_q == ARB) && !bus.tx_busy && pick_found;
    byte_d = '0;
    last_d = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IDW'(i)) begin
        byte_d = bus.req_data[8*i +: 8];
        last_d = bus.req_last[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB;
      rr_ptr_q   <= '0;
      gnt_id_q   <= '0;
      gnt_lock_q <= 1'b0;
      tx_data_q  <= '0;
      tx_pluse_q <= 1'b0;
      last_q     <= 1'b0;
      ack_cnt_q  <= '0;
      idle_cnt_q <= '0;
      ack_err_q  <= 1'b0;
      lock_err_q <= 1'b0;
      tx_cnt_q   <= '0;
    end else begin
      case (state_q)
        ARB: begin
          tx_pluse_q <= 1'b0;
          if (win) begin
            tx_data_q  <= byte_d;
            last_q     <= last_d;
            gnt_id_q   <= pick_idx;
            idle_cnt_q <= '0;
            ack_cnt_q  <= '0;
            tx_pluse_q <= 1'b1;
            state_q    <= ISSUE;
          end else if (gnt_lock_q && !bus.req_valid[gnt_id_q]) begin
            if (idle_cnt_q == LOCK_TIMEOUT - 32'd1) begin
              gnt_lock_q <= 1'b0;
              lock_err_q <= 1'b1;
              rr_ptr_q   <= next_id(gnt_id_q);
              idle_cnt_q <= '0;
            end else begin
              idle_cnt_q <= idle_cnt_q + 32'd1;
            end
          end
        end
        ISSUE: begin
          // The pulse cycle counts as the first of the ACK_TIMEOUT window.
          tx_pluse_q <= 1'b0;
          ack_cnt_q  <= ack_cnt_q + 16'd1;
          state_q    <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (bus.tx_busy) begin
            state_q <= WAIT_DONE;
          end else if (ack_cnt_q == ACK_TIMEOUT - 16'd1) begin
            ack_err_q  <= 1'b1;
            gnt_lock_q <= 1'b0;
            rr_ptr_q   <= next_id(gnt_id_q);
            state_q    <= ARB;
          end else begin
            ack_cnt_q <= ack_cnt_q + 16'd1;
          end
        end
        WAIT_DONE: begin
          if (!bus.tx_busy) begin
            tx_cnt_q <= tx_cnt_q + 16'd1;
            state_q  <= ARB;
            if (last_q) begin
              gnt_lock_q <= 1'b0;
              rr_ptr_q   <= next_id(gnt_id_q);
            end else begin
              gnt_lock_q <= 1'b1;
            end
          end
        end
        default: state_q <= ARB;
      endcase
    end
  end

  assign bus.req_ready = win ? (NUM_REQ'(1) << pick_idx) : '0;
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_pluse  = tx_pluse_q;
  assign gnt_id        = gnt_id_q;
  assign gnt_lock      = gnt_lock_q;
  assign ack_err       = ack_err_q;
  assign lock_err      = lock_err_q;
  assign tx_cnt        = tx_cnt_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed requester traffic, a uart_tx
// busy model, and a monitor checking every tx_pluse against expected bytes.
module tb_uart_tx_arbiter;

  localparam int NR = 4;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] id;
    logic       lock;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        busy_en;
  logic [1:0]  gnt_id;
  logic        gnt_lock;
  logic        ack_err;
  logic        lock_err;
  logic [15:0] tx_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int ready_cnt0 = 0;

  exp_t       exp_q[$];
  logic [8:0] rq[NR][$];

  uart_tx_arbiter_if #(.NUM_REQ(NR)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ      (NR),
    .ACK_TIMEOUT  (16'd8),
    .LOCK_TIMEOUT (32'd100)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .gnt_id   (gnt_id),
    .gnt_lock (gnt_lock),
    .ack_err  (ack_err),
    .lock_err (lock_err),
    .tx_cnt   (tx_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send(input int i, input logic [7:0] d, input logic last);
    rq[i].push_back({last, d});
  endtask

  task automatic expect_tx(input logic [7:0] d, input logic [1:0] id, input logic lock);
    exp_q.push_back('{data: d, id: id, lock: lock});
  endtask

  function automatic bit rq_pending();
    for (int i = 0; i < NR; i++)
      if (rq[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  // uart_tx model: busy rises two cycles after the pulse and lasts 20 cycles
  initial begin
    bus.tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      if (bus.tx_pluse && busy_en) begin
        @(posedge clk);
        #1 bus.tx_busy = 1'b1;
        repeat (20) @(posedge clk);
        #1 bus.tx_busy = 1'b0;
      end
    end
  end

  // requester driver: present queue heads, pop on handshake
  initial begin
    logic [NR-1:0] hs;
    logic [8:0]    item;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    forever begin
      @(negedge clk);
      hs = bus.req_valid & bus.req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (hs[i]) void'(rq[i].pop_front());
        if (rq[i].size() != 0) begin
          item = rq[i][0];
          bus.req_valid[i]       = 1'b1;
          bus.req_data[8*i +: 8] = item[7:0];
          bus.req_last[i]        = item[8];
        end else begin
          bus.req_valid[i]       = 1'b0;
          bus.req_data[8*i +: 8] = 8'h00;
          bus.req_last[i]        = 1'b0;
        end
      end
    end
  end

  // monitor: pops the scoreboard on every tx_pluse
  initial begin
    logic prev_pulse;
    exp_t e;
    prev_pulse = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.req_ready[0]) ready_cnt0++;
        if (bus.req_ready != '0) begin
          chk("ready_onehot", 32'($countones(bus.req_ready)), 32'd1);
          chk("ready_while_busy", 32'(bus.tx_busy), 32'd0);
        end
        if (bus.tx_pluse) begin
          chk("pulse_width", 32'(prev_pulse), 32'd0);
          chk("pulse_while_busy", 32'(bus.tx_busy), 32'd0);
          if (exp_q.size() == 0) begin
            chk("unexpected_pulse", 32'(bus.tx_data), 32'hFFFF);
          end else begin
            e = exp_q.pop_front();
            chk("tx_data", 32'(bus.tx_data), 32'(e.data));
            chk("pulse_gnt_id", 32'(gnt_id), 32'(e.id));
            chk("pulse_gnt_lock", 32'(gnt_lock), 32'(e.lock));
          end
        end
      end
      prev_pulse = bus.tx_pluse;
    end
  end

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || rq_pending()) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (12) @(negedge clk);
    while (bus.tx_busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    if (n >= 3000) chk({tag, "_timeout"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_tx_cnt"}, 32'(tx_cnt), 32'd0);
    chk({tag, "_gnt_id"}, 32'(gnt_id), 32'd0);
    chk({tag, "_gnt_lock"}, 32'(gnt_lock), 32'd0);
    chk({tag, "_ack_err"}, 32'(ack_err), 32'd0);
    chk({tag, "_lock_err"}, 32'(lock_err), 32'd0);
    chk({tag, "_tx_data"}, 32'(bus.tx_data), 32'd0);
    chk({tag, "_tx_pluse"}, 32'(bus.tx_pluse), 32'd0);
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
    chk({tag, "_rr_ptr"}, 32'(dut.rr_ptr_q), 32'd0);
  endtask

  initial begin
    int n;
    rst     = 1'b1;
    busy_en = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset("rst0");

    // single byte from requester 0
    expect_tx(8'h55, 2'd0, 1'b0);
    send(0, 8'h55, 1'b1);
    wait_idle("t1");
    chk("t1_tx_cnt", 32'(tx_cnt), 32'd1);
    chk("t1_gnt_lock", 32'(gnt_lock), 32'd0);
    chk("t1_rr_ptr", 32'(dut.rr_ptr_q), 32'd1);
    chk("t1_ready_cycles", 32'(ready_cnt0), 32'd1);

    // all four requesters, two single-byte messages each
    do_reset();
    check_reset("rst1");
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NR; i++) begin
        expect_tx(8'hA0 + 8'(i), 2'(i), 1'b0);
        send(i, 8'hA0 + 8'(i), 1'b1);
      end
    wait_idle("t2");
    chk("t2_tx_cnt", 32'(tx_cnt), 32'd8);
    chk("t2_rr_ptr", 32'(dut.rr_ptr_q), 32'd0);

    // move the pointer to 2, then a locked 3-byte packet competing with req 1
    expect_tx(8'h10, 2'd1, 1'b0);
    send(1, 8'h10, 1'b1);
    wait_idle("t3a");
    expect_tx(8'h2A, 2'd2, 1'b0);
    expect_tx(8'h2B, 2'd2, 1'b1);
    expect_tx(8'h2C, 2'd2, 1'b1);
    expect_tx(8'h11, 2'd1, 1'b0);
    send(2, 8'h2A, 1'b0);
    send(2, 8'h2B, 1'b0);
    send(2, 8'h2C, 1'b1);
    send(1, 8'h11, 1'b1);
    wait_idle("t3");
    chk("t3_tx_cnt", 32'(tx_cnt), 32'd13);
    chk("t3_gnt_lock", 32'(gnt_lock), 32'd0);

    // dead transmitter: both bytes dropped after the ack timeout
    busy_en = 1'b0;
    chk("t4_ack_err_pre", 32'(ack_err), 32'd0);
    expect_tx(8'hD2, 2'd2, 1'b0);
    expect_tx(8'hD3, 2'd3, 1'b0);
    send(2, 8'hD2, 1'b1);
    send(3, 8'hD3, 1'b1);
    n = 0;
    while (!bus.tx_pluse && n < 50) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (!ack_err && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t4_ack_err_delay", 32'(n), 32'd8);
    wait_idle("t4");
    busy_en = 1'b1;
    chk("t4_tx_cnt", 32'(tx_cnt), 32'd13);
    chk("t4_ack_err", 32'(ack_err), 32'd1);
    chk("t4_rr_ptr", 32'(dut.rr_ptr_q), 32'd0);

    // lock force-release after 100 idle cycles, then requester 0 served
    expect_tx(8'h33, 2'd3, 1'b0);
    send(3, 8'h33, 1'b0);
    n = 0;
    while (!gnt_lock && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t5_locked", 32'(gnt_lock), 32'd1);
    expect_tx(8'h44, 2'd0, 1'b0);
    send(0, 8'h44, 1'b1);
    n = 0;
    while (!lock_err && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("t5_lock_err_delay", 32'(n), 32'd100);
    wait_idle("t5");
    chk("t5_lock_err", 32'(lock_err), 32'd1);
    chk("t5_gnt_lock", 32'(gnt_lock), 32'd0);
    chk("t5_tx_cnt", 32'(tx_cnt), 32'd15);

    // reset while the transmitter is busy (WAIT_DONE)
    expect_tx(8'h66, 2'd1, 1'b0);
    send(1, 8'h66, 1'b1);
    n = 0;
    while (!bus.tx_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("t6_busy_at_rst", 32'(bus.tx_busy), 32'd1);
    do_reset();
    check_reset("rst2");
    expect_tx(8'h77, 2'd2, 1'b0);
    send(2, 8'h77, 1'b1);
    wait_idle("t6");
    chk("t6_tx_cnt", 32'(tx_cnt), 32'd1);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
